// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multi-cycle MIPS-style control sequencer:
//   - state encoding (FETCH=0 .. WB=4, TRAP=7)
//   - opcode / funct constants of the supported instruction subset
//   - decode classes latched by the sequencer
//   - imm_sel, pc_src and alu_op codes plus per-class lookup helpers
// No ports (package).
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [1:0] IMM_ZERO  = 2'b00;
    localparam logic [1:0] IMM_SEXT  = 2'b10;
    localparam logic [1:0] IMM_SHAMT = 2'b11;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLL = 4'd4;
    localparam logic [3:0] ALU_SRL = 4'd5;

    typedef enum logic [3:0] {
        CL_ADD, CL_SUB, CL_AND, CL_OR, CL_SLL, CL_SRL,
        CL_ADDI, CL_LW, CL_SW, CL_BEQ, CL_J, CL_ILLEGAL
    } class_e;

    function automatic logic [1:0] imm_sel_of(input class_e c);
        case (c)
            CL_ADDI, CL_LW, CL_SW, CL_BEQ: return IMM_SEXT;
            CL_SLL, CL_SRL:                return IMM_SHAMT;
            default:                       return IMM_ZERO;
        endcase
    endfunction

    function automatic logic [3:0] alu_op_of(input class_e c);
        case (c)
            CL_SUB, CL_BEQ: return ALU_SUB;
            CL_AND:         return ALU_AND;
            CL_OR:          return ALU_OR;
            CL_SLL:         return ALU_SLL;
            CL_SRL:         return ALU_SRL;
            default:        return ALU_ADD;
        endcase
    endfunction

    // Shifts take their amount from the shamt field, so they use the immediate port too.
    function automatic logic uses_imm_b(input class_e c);
        case (c)
            CL_ADDI, CL_LW, CL_SW, CL_SLL, CL_SRL: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic is_rtype(input class_e c);
        case (c)
            CL_ADD, CL_SUB, CL_AND, CL_OR, CL_SLL, CL_SRL: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm_if
// Instruction/data memory handshake bundle between the sequencer and memories.
//   imem_req  : instruction fetch request           (master -> slave)
//   imem_ack  : fetch complete, data valid this cycle (slave -> master)
//   dmem_req  : data memory request                 (master -> slave)
//   dmem_we   : 1 = store, 0 = load, valid with req (master -> slave)
//   dmem_ack  : data access complete                (slave -> master)
// Modports: master (sequencer), slave (memory side).
// ---------------------------------------------------------------------------
interface mc_ctrl_fsm_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ack, dmem_ack
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ack, dmem_ack
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// ---------------------------------------------------------------------------
// mc_ctrl_decode
// Combinational opcode/funct -> instruction class decoder.
// Ports:
//   opcode [5:0] in  : instr[31:26]
//   funct  [5:0] in  : instr[5:0]
//   cls          out : decoded class, CL_ILLEGAL for anything unsupported
// ---------------------------------------------------------------------------
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output class_e     cls
);

    always_comb begin
        cls = CL_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  cls = CL_ADD;
                    FN_SUB:  cls = CL_SUB;
                    FN_AND:  cls = CL_AND;
                    FN_OR:   cls = CL_OR;
                    FN_SLL:  cls = CL_SLL;
                    FN_SRL:  cls = CL_SRL;
                    default: cls = CL_ILLEGAL;
                endcase
            end
            OP_ADDI: cls = CL_ADDI;
            OP_LW:   cls = CL_LW;
            OP_SW:   cls = CL_SW;
            OP_BEQ:  cls = CL_BEQ;
            OP_J:    cls = CL_J;
            default: cls = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
// Multi-cycle control sequencer (FETCH -> DECODE -> EXEC -> MEM -> WB) for a
// 32-bit MIPS-style datapath. Memory accesses use req/ack so variable-latency
// memories stall the sequence. Illegal opcodes and (optionally) fetch timeouts
// park the machine in TRAP until reset.
//
// Parameters:
//   ALU_OP_W     : width of alu_op
//   IMEM_TIMEOUT : stall cycles in FETCH before trapping, 0 = wait forever
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   opcode, funct      : instruction register fields
//   alu_zero           : ALU zero flag (BEQ)
//   mif (master)       : imem/dmem req/ack handshakes, dmem_we
//   ir_we, pc_we       : IR load, PC update strobes
//   pc_src, imm_sel    : PC source and immediate-extension selects
//   alu_src_b, alu_op  : ALU B-operand select and operation
//   reg_dst, reg_we    : register destination select and write enable
//   mem_to_reg         : write-back from load data
//   trap               : sticky illegal-instruction / timeout flag
//   state_o            : current state for debug
// Optional (macro MC_CTRL_PERF_EN):
//   retired_cnt, stall_cnt : 32-bit wrapping performance counters
// ---------------------------------------------------------------------------
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_OP_W     = 4,
    parameter int IMEM_TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                alu_zero,
    mc_ctrl_fsm_if.master       mif,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          pc_src,
    output logic [1:0]          imm_sel,
    output logic                alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                reg_dst,
    output logic                reg_we,
    output logic                mem_to_reg,
    output logic                trap,
    output logic [2:0]          state_o
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0]         retired_cnt,
    output logic [31:0]         stall_cnt
`endif
);

    localparam int CNT_W = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
    // Trap fires on the stall cycle whose count would reach IMEM_TIMEOUT.
    localparam logic [CNT_W-1:0] TO_LAST = (IMEM_TIMEOUT > 0) ? CNT_W'(IMEM_TIMEOUT - 1) : '0;

    state_e           r_state;
    state_e           w_next;
    class_e           r_class;
    class_e           w_class;
    logic [CNT_W-1:0] r_to_cnt;
    logic [3:0]       w_alu;

    mc_ctrl_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .cls    (w_class)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_FETCH;
            r_class  <= CL_ILLEGAL;
            r_to_cnt <= '0;
        end else begin
            r_state <= w_next;
            // IR is stable from DECODE onward, so the class is captured once here.
            if (r_state == S_DECODE) begin
                r_class <= w_class;
            end
            if (r_state == S_FETCH && !mif.imem_ack) begin
                r_to_cnt <= r_to_cnt + CNT_W'(1);
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (mif.imem_ack) begin
                    w_next = S_DECODE;
                end else if (IMEM_TIMEOUT != 0 && r_to_cnt == TO_LAST) begin
                    w_next = S_TRAP;
                end
            end
            S_DECODE: begin
                if (w_class == CL_J) begin
                    w_next = S_FETCH;
                end else if (w_class == CL_ILLEGAL) begin
                    w_next = S_TRAP;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_class)
                    CL_BEQ:       w_next = S_FETCH;
                    CL_LW, CL_SW: w_next = S_MEM;
                    default:      w_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (mif.dmem_ack) begin
                    w_next = (r_class == CL_SW) ? S_FETCH : S_WB;
                end
            end
            S_WB:    w_next = S_FETCH;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_TRAP;
        endcase
    end

    // Outputs are held at their idle values while rst_n is low, whatever the
    // state register still holds.
    always_comb begin
        mif.imem_req = 1'b0;
        mif.dmem_req = 1'b0;
        mif.dmem_we  = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_PLUS4;
        imm_sel      = IMM_ZERO;
        alu_src_b    = 1'b0;
        w_alu        = ALU_ADD;
        reg_dst      = 1'b0;
        reg_we       = 1'b0;
        mem_to_reg   = 1'b0;
        trap         = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    mif.imem_req = 1'b1;
                    ir_we        = mif.imem_ack;
                    pc_we        = mif.imem_ack;
                    pc_src       = PC_PLUS4;
                end
                S_DECODE: begin
                    imm_sel = imm_sel_of(w_class);
                    if (w_class == CL_J) begin
                        pc_we  = 1'b1;
                        pc_src = PC_JUMP;
                    end
                end
                S_EXEC: begin
                    imm_sel   = imm_sel_of(r_class);
                    alu_src_b = uses_imm_b(r_class);
                    w_alu     = alu_op_of(r_class);
                    if (r_class == CL_BEQ) begin
                        pc_we  = alu_zero;
                        pc_src = PC_BRANCH;
                    end
                end
                S_MEM: begin
                    mif.dmem_req = 1'b1;
                    mif.dmem_we  = (r_class == CL_SW);
                end
                S_WB: begin
                    reg_we     = 1'b1;
                    reg_dst    = is_rtype(r_class);
                    mem_to_reg = (r_class == CL_LW);
                end
                S_TRAP: trap = 1'b1;
                default: ;
            endcase
        end
    end

    assign alu_op  = ALU_OP_W'(w_alu);
    assign state_o = r_state;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] r_retired_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_retire;
    logic        w_stall;

    // Every entry into FETCH from another state completes an instruction.
    assign w_retire = (r_state != S_FETCH) && (w_next == S_FETCH);
    assign w_stall  = (mif.imem_req && !mif.imem_ack) || (mif.dmem_req && !mif.dmem_ack);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retired_cnt <= '0;
            r_stall_cnt   <= '0;
        end else begin
            if (w_retire) begin
                r_retired_cnt <= r_retired_cnt + 32'd1;
            end
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign retired_cnt = r_retired_cnt;
    assign stall_cnt   = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_fsm
// Scoreboard bench for mc_ctrl_fsm. Two instances: u_dut (no fetch timeout)
// runs the instruction sequences, u_dut2 (IMEM_TIMEOUT=5) runs a starved fetch.
// Stimulus pushes the hand-computed per-cycle output vector into a queue; the
// monitor pops and compares on the falling edge.
// Expected vector layout: {state,imem_req,dmem_req,dmem_we,ir_we,pc_we,
//                          pc_src,imm_sel,alu_src_b,alu_op,reg_dst,reg_we,
//                          mem_to_reg,trap}
// ---------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rst2_n;
    logic [5:0] opcode, funct;
    logic       alu_zero;
    logic       done2 = 1'b0;

    mc_ctrl_fsm_if mif ();
    mc_ctrl_fsm_if mif2 ();

    logic       ir_we, pc_we, alu_src_b, reg_dst, reg_we, mem_to_reg, trap;
    logic [1:0] pc_src, imm_sel;
    logic [3:0] alu_op;
    logic [2:0] state_o;
    logic       ir_we2, pc_we2, alu_src_b2, reg_dst2, reg_we2, mem_to_reg2, trap2;
    logic [1:0] pc_src2, imm_sel2;
    logic [3:0] alu_op2;
    logic [2:0] state_o2;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] ret1, stl1, ret2, stl2;
`endif

    mc_ctrl_fsm #(.ALU_OP_W(4), .IMEM_TIMEOUT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .mif(mif), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .imm_sel(imm_sel),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst), .reg_we(reg_we),
        .mem_to_reg(mem_to_reg), .trap(trap), .state_o(state_o)
`ifdef MC_CTRL_PERF_EN
        , .retired_cnt(ret1), .stall_cnt(stl1)
`endif
    );

    mc_ctrl_fsm #(.ALU_OP_W(4), .IMEM_TIMEOUT(5)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .mif(mif2), .ir_we(ir_we2), .pc_we(pc_we2), .pc_src(pc_src2), .imm_sel(imm_sel2),
        .alu_src_b(alu_src_b2), .alu_op(alu_op2), .reg_dst(reg_dst2), .reg_we(reg_we2),
        .mem_to_reg(mem_to_reg2), .trap(trap2), .state_o(state_o2)
`ifdef MC_CTRL_PERF_EN
        , .retired_cnt(ret2), .stall_cnt(stl2)
`endif
    );

    logic [20:0] act1, act2;
    assign act1 = {state_o, mif.imem_req, mif.dmem_req, mif.dmem_we, ir_we, pc_we,
                   pc_src, imm_sel, alu_src_b, alu_op, reg_dst, reg_we, mem_to_reg, trap};
    assign act2 = {state_o2, mif2.imem_req, mif2.dmem_req, mif2.dmem_we, ir_we2, pc_we2,
                   pc_src2, imm_sel2, alu_src_b2, alu_op2, reg_dst2, reg_we2, mem_to_reg2, trap2};

    typedef struct {
        logic [20:0] v;
        string       tag;
        logic        pchk;
        logic [31:0] ret;
        logic [31:0] stl;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t m1, m2;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [5:0] fn_t[4]  = '{6'h22, 6'h24, 6'h25, 6'h02};
    int         alu_t[4] = '{1, 2, 3, 5};
    int         sh_t[4]  = '{0, 0, 0, 1};

    function automatic logic [20:0] ev(input int st, input int imr, input int dmr, input int dwe,
                                       input int irw, input int pcw, input int pcs, input int ims,
                                       input int sb, input int aop, input int rd, input int rw,
                                       input int mr, input int tr);
        return {3'(st), 1'(imr), 1'(dmr), 1'(dwe), 1'(irw), 1'(pcw), 2'(pcs), 2'(ims),
                1'(sb), 4'(aop), 1'(rd), 1'(rw), 1'(mr), 1'(tr)};
    endfunction

    task automatic push1(input logic [20:0] v, input string tag, input logic pchk,
                         input logic [31:0] ret, input logic [31:0] stl);
        exp_t e;
        e.v = v; e.tag = tag; e.pchk = pchk; e.ret = ret; e.stl = stl;
        q1.push_back(e);
    endtask

    task automatic step1(input logic [20:0] v, input string tag);
        push1(v, tag, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic stepp(input logic [20:0] v, input string tag,
                         input logic [31:0] ret, input logic [31:0] stl);
        push1(v, tag, 1'b1, ret, stl);
        @(posedge clk); #1;
    endtask

    task automatic step2(input logic [20:0] v, input string tag, input logic pchk,
                         input logic [31:0] stl);
        exp_t e;
        e.v = v; e.tag = tag; e.pchk = pchk; e.ret = 32'd0; e.stl = stl;
        q2.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input int waits);
        opcode = op;
        funct  = fn;
        mif.imem_ack = 1'b0;
        for (int k = 0; k < waits; k++) step1(ev(0,1,0,0,0,0,0,0,0,0,0,0,0,0), "fetch_wait");
        mif.imem_ack = 1'b1;
        step1(ev(0,1,0,0,1,1,0,0,0,0,0,0,0,0), "fetch_ack");
        mif.imem_ack = 1'b0;
    endtask

    // Monitor
    always @(negedge clk) begin
        if (q1.size() > 0) begin
            m1 = q1.pop_front();
            n_cmp++;
            if (act1 !== m1.v) begin
                n_bad++;
                $display("FAIL %s (dut): got %h, expected %h", m1.tag, act1, m1.v);
            end
`ifdef MC_CTRL_PERF_EN
            if (m1.pchk) begin
                n_cmp++;
                if (ret1 !== m1.ret || stl1 !== m1.stl) begin
                    n_bad++;
                    $display("FAIL %s_perf (dut): got ret=%0d stall=%0d, expected ret=%0d stall=%0d",
                             m1.tag, ret1, stl1, m1.ret, m1.stl);
                end
            end
`endif
        end
        if (q2.size() > 0) begin
            m2 = q2.pop_front();
            n_cmp++;
            if (act2 !== m2.v) begin
                n_bad++;
                $display("FAIL %s (dut2): got %h, expected %h", m2.tag, act2, m2.v);
            end
`ifdef MC_CTRL_PERF_EN
            if (m2.pchk) begin
                n_cmp++;
                if (ret2 !== m2.ret || stl2 !== m2.stl) begin
                    n_bad++;
                    $display("FAIL %s_perf (dut2): got ret=%0d stall=%0d, expected ret=%0d stall=%0d",
                             m2.tag, ret2, stl2, m2.ret, m2.stl);
                end
            end
`endif
        end
    end

    // Fetch-timeout instance: ack never arrives, trap from cycle 6.
    initial begin
        rst2_n = 1'b0;
        mif2.imem_ack = 1'b0;
        mif2.dmem_ack = 1'b0;
        @(posedge clk); #1;
        step2(ev(0,0,0,0,0,0,0,0,0,0,0,0,0,0), "to_reset", 1'b0, 32'd0);
        rst2_n = 1'b1;
        for (int i = 0; i < 5; i++) step2(ev(0,1,0,0,0,0,0,0,0,0,0,0,0,0), "to_wait", 1'b0, 32'd0);
        mif2.imem_ack = 1'b1;
        mif2.dmem_ack = 1'b1;
        for (int i = 0; i < 3; i++) step2(ev(7,0,0,0,0,0,0,0,0,0,0,0,0,1), "to_trap", 1'b1, 32'd5);
        done2 = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Main sequence on u_dut
    initial begin
        rst_n = 1'b0; opcode = 6'h00; funct = 6'h00; alu_zero = 1'b0;
        mif.imem_ack = 1'b0; mif.dmem_ack = 1'b0;
        @(posedge clk); #1;
        stepp(ev(0,0,0,0,0,0,0,0,0,0,0,0,0,0), "reset", 32'd0, 32'd0);
        rst_n = 1'b1;

        // ADD: F,D,E,W
        fetch(6'h00, 6'h20, 0);
        step1(ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0), "add_dec");
        step1(ev(2,0,0,0,0,0,0,0,0,0,0,0,0,0), "add_exe");
        step1(ev(4,0,0,0,0,0,0,0,0,0,1,1,0,0), "add_wb");

        // SUB, AND, OR, SRL
        for (int i = 0; i < 4; i++) begin
            fetch(6'h00, fn_t[i], 0);
            step1(ev(1,0,0,0,0,0,0,sh_t[i]*3,0,0,0,0,0,0), "r_dec");
            step1(ev(2,0,0,0,0,0,0,sh_t[i]*3,sh_t[i],alu_t[i],0,0,0,0), "r_exe");
            step1(ev(4,0,0,0,0,0,0,0,0,0,1,1,0,0), "r_wb");
        end

        // SLL
        fetch(6'h00, 6'h00, 0);
        step1(ev(1,0,0,0,0,0,0,3,0,0,0,0,0,0), "sll_dec");
        step1(ev(2,0,0,0,0,0,0,3,1,4,0,0,0,0), "sll_exe");
        step1(ev(4,0,0,0,0,0,0,0,0,0,1,1,0,0), "sll_wb");

        // ADDI
        fetch(6'h08, 6'h00, 0);
        step1(ev(1,0,0,0,0,0,0,2,0,0,0,0,0,0), "addi_dec");
        step1(ev(2,0,0,0,0,0,0,2,1,0,0,0,0,0), "addi_exe");
        step1(ev(4,0,0,0,0,0,0,0,0,0,0,1,0,0), "addi_wb");

        // LW, stray acks in D/E, dmem_ack 3 cycles late
        fetch(6'h23, 6'h00, 0);
        mif.imem_ack = 1'b1; mif.dmem_ack = 1'b1;
        step1(ev(1,0,0,0,0,0,0,2,0,0,0,0,0,0), "lw_dec");
        step1(ev(2,0,0,0,0,0,0,2,1,0,0,0,0,0), "lw_exe");
        mif.imem_ack = 1'b0; mif.dmem_ack = 1'b0;
        for (int i = 0; i < 3; i++) step1(ev(3,0,1,0,0,0,0,0,0,0,0,0,0,0), "lw_mem_wait");
        mif.dmem_ack = 1'b1;
        step1(ev(3,0,1,0,0,0,0,0,0,0,0,0,0,0), "lw_mem_ack");
        mif.dmem_ack = 1'b0;
        step1(ev(4,0,0,0,0,0,0,0,0,0,0,1,1,0), "lw_wb");

        // SW with 2 fetch waits and 1 data wait
        fetch(6'h2B, 6'h00, 2);
        step1(ev(1,0,0,0,0,0,0,2,0,0,0,0,0,0), "sw_dec");
        step1(ev(2,0,0,0,0,0,0,2,1,0,0,0,0,0), "sw_exe");
        step1(ev(3,0,1,1,0,0,0,0,0,0,0,0,0,0), "sw_mem_wait");
        mif.dmem_ack = 1'b1;
        step1(ev(3,0,1,1,0,0,0,0,0,0,0,0,0,0), "sw_mem_ack");
        mif.dmem_ack = 1'b0;

        // BEQ taken / not taken
        fetch(6'h04, 6'h00, 0);
        step1(ev(1,0,0,0,0,0,0,2,0,0,0,0,0,0), "beq1_dec");
        alu_zero = 1'b1;
        step1(ev(2,0,0,0,0,1,1,2,0,1,0,0,0,0), "beq1_exe");
        fetch(6'h04, 6'h00, 0);
        step1(ev(1,0,0,0,0,0,0,2,0,0,0,0,0,0), "beq0_dec");
        alu_zero = 1'b0;
        step1(ev(2,0,0,0,0,0,1,2,0,1,0,0,0,0), "beq0_exe");

        // J
        fetch(6'h02, 6'h00, 0);
        step1(ev(1,0,0,0,0,1,2,0,0,0,0,0,0,0), "j_dec");

        // Reset in the middle of a load's MEM stall
        fetch(6'h23, 6'h00, 0);
        step1(ev(1,0,0,0,0,0,0,2,0,0,0,0,0,0), "lw2_dec");
        step1(ev(2,0,0,0,0,0,0,2,1,0,0,0,0,0), "lw2_exe");
        step1(ev(3,0,1,0,0,0,0,0,0,0,0,0,0,0), "lw2_mem_wait");
        rst_n = 1'b0;
        step1(ev(3,0,0,0,0,0,0,0,0,0,0,0,0,0), "rst_in_mem");
        rst_n = 1'b1;
        step1(ev(0,1,0,0,0,0,0,0,0,0,0,0,0,0), "rst_refetch");

        // Illegal opcode: trap, later acks ignored
        fetch(6'h3F, 6'h00, 0);
        step1(ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0), "ill_dec");
        mif.imem_ack = 1'b1; mif.dmem_ack = 1'b1;
        for (int i = 0; i < 3; i++) step1(ev(7,0,0,0,0,0,0,0,0,0,0,0,0,1), "trap_hold");
        mif.imem_ack = 1'b0; mif.dmem_ack = 1'b0;

        // Reset out of TRAP, then ADD (1 fetch wait), SW (2 data waits), J
        rst_n = 1'b0;
        step1(ev(7,0,0,0,0,0,0,0,0,0,0,0,0,0), "rst_from_trap");
        rst_n = 1'b1;
        opcode = 6'h00; funct = 6'h20;
        stepp(ev(0,1,0,0,0,0,0,0,0,0,0,0,0,0), "perf_start", 32'd0, 32'd0);
        fetch(6'h00, 6'h20, 0);
        step1(ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0), "p_add_dec");
        step1(ev(2,0,0,0,0,0,0,0,0,0,0,0,0,0), "p_add_exe");
        step1(ev(4,0,0,0,0,0,0,0,0,0,1,1,0,0), "p_add_wb");
        fetch(6'h2B, 6'h00, 0);
        step1(ev(1,0,0,0,0,0,0,2,0,0,0,0,0,0), "p_sw_dec");
        step1(ev(2,0,0,0,0,0,0,2,1,0,0,0,0,0), "p_sw_exe");
        step1(ev(3,0,1,1,0,0,0,0,0,0,0,0,0,0), "p_sw_wait");
        step1(ev(3,0,1,1,0,0,0,0,0,0,0,0,0,0), "p_sw_wait");
        mif.dmem_ack = 1'b1;
        step1(ev(3,0,1,1,0,0,0,0,0,0,0,0,0,0), "p_sw_ack");
        mif.dmem_ack = 1'b0;
        fetch(6'h02, 6'h00, 0);
        step1(ev(1,0,0,0,0,1,2,0,0,0,0,0,0,0), "p_j_dec");
        stepp(ev(0,1,0,0,0,0,0,0,0,0,0,0,0,0), "perf_end", 32'd3, 32'd3);

        @(negedge clk); #1;
        n_cmp++;
        if (!done2 || q1.size() != 0 || q2.size() != 0) begin
            n_bad++;
            $display("FAIL drain: done2=%0d q1=%0d q2=%0d, expected done2=1 q1=0 q2=0",
                     done2, q1.size(), q2.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the 32-bit MIPS-style datapath.
- Decodes opcode/funct from the instruction register and steps FETCH→DECODE→EXEC→MEM→WB.
- Drives immediate-extension select, ALU op, register-file/memory enables and PC update.
- Uses req/ack handshakes to instruction and data memory, so variable-latency memories stall the sequence.

Parameters:
- ALU_OP_W, 4, width of alu_op.
- IMEM_TIMEOUT, 0, cycles to wait for imem_ack before trapping; 0 = wait forever.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk edge.
- opcode  in  6  instr[31:26] from instruction register.
- funct  in  6  instr[5:0] from instruction register.
- alu_zero  in  1  ALU zero flag.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  instruction fetch complete; data valid this cycle.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req.
- dmem_ack  in  1  data access complete.
- ir_we  out  1  load instruction register.
- pc_we  out  1  update PC.
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target.
- imm_sel  out  2  00 zero, 10 I-type sign-extend, 11 shamt instr[10:6].
- alu_src_b  out  1  0 = register rt, 1 = immediate.
- alu_op  out  ALU_OP_W  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRL.
- reg_dst  out  1  1 = rd, 0 = rt.
- reg_we  out  1  register-file write enable.
- mem_to_reg  out  1  write-back source is load data.
- trap  out  1  sticky illegal-instruction / timeout flag.
- state_o  out  3  current state, for debug.

Behaviour:
- Reset (rst_n=0 at posedge): state=FETCH, trap=0, timeout counter=0.
  - All strobes (imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we) are 0 during reset.
  - Other outputs: pc_src=00, imm_sel=00, alu_op=ADD, alu_src_b=0, reg_dst=0, mem_to_reg=0.
- Reset mid-operation aborts the sequence; req lines drop the cycle after reset is sampled.
- All outputs are Moore-decoded from state plus the latched decode class.
  - Exception: ir_we=imem_ack and pc_we in FETCH=imem_ack (PC+4).
- Decode classes (latched in DECODE):
  - R-type (opcode 000000) with funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 000000 SLL, 000010 SRL.
  - Immediate and memory: ADDI 001000, LW 100011, SW 101011.
  - Control flow: BEQ 000100, J 000010.
  - Anything else = ILLEGAL.
- FETCH: imem_req=1 until imem_ack.
  - On ack: ir_we=1, pc_we=1, pc_src=00, then go to DECODE.
  - Counter counts stall cycles. If IMEM_TIMEOUT≠0 and count reaches IMEM_TIMEOUT, go to TRAP.
- DECODE: imm_sel set per class.
  - 10 for ADDI/LW/SW/BEQ.
  - 11 for SLL/SRL.
  - 00 otherwise.
  - J: pc_we=1, pc_src=10, then FETCH. ILLEGAL: go to TRAP. Others: go to EXEC.
- EXEC:
  - imm_sel is held.
  - alu_src_b=1 for ADDI/LW/SW/SLL/SRL.
  - alu_op per class: ADDI/LW/SW use ADD, BEQ uses SUB.
  - BEQ: pc_we=alu_zero, pc_src=01, then FETCH.
  - LW/SW go to MEM. R-type and ADDI go to WB.
- MEM: dmem_req=1; dmem_we=1 for SW. Held stable until dmem_ack.
  - On ack: SW goes to FETCH, LW goes to WB.
  - No timeout applies.
- WB: reg_we=1 for exactly one cycle, then FETCH.
  - reg_dst=1 for R-type.
  - mem_to_reg=1 for LW.
- TRAP: all strobes 0, trap=1. Left only by reset.
- Zero-wait latency (clocks per instruction): R/ADDI 4, LW 5, SW 4, BEQ 3, J 2.
- An ack arriving while the matching req is 0 is ignored.
- imem_req and dmem_req are never high in the same cycle.

Optional Feature:
- Macro MC_CTRL_PERF_EN.
- When defined, adds output retired_cnt[31:0] and stall_cnt[31:0].
  - Both reset to 0 and wrap modulo 2^32.
  - retired_cnt increments on each transition into FETCH from DECODE(J), EXEC(BEQ), MEM(SW) or WB.
  - stall_cnt increments each cycle with an outstanding req and no ack.
- When not defined: neither port exists and no counter flops are built.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7;
  - opcode and funct constants;
  - imm_sel codes, alu_op codes and pc_src codes.
- One sub-module, mc_ctrl_decode: combinational opcode/funct → class decoder. It is unit-testable on its own.

Test Plan:
- Zero-wait ack, IR=ADD (op 0, funct 0x20) → states F,D,E,W; reg_we=1 only in cycle 4, reg_dst=1, alu_op=0.
- LW with dmem_ack delayed 3 cycles → dmem_req high 4 cycles with dmem_we=0; WB with mem_to_reg=1; total 8 cycles.
- BEQ with alu_zero=1 → pc_we=1, pc_src=01 in EXEC. With alu_zero=0 → pc_we=0. Both paths return to FETCH in 3 cycles.
- SLL → imm_sel=11 in DECODE and EXEC, alu_src_b=1, alu_op=4. Opcode 0x3F → trap=1 after DECODE, strobes 0 forever.
- IMEM_TIMEOUT=5, imem_ack held low → trap=1 on cycle 6. rst_n low mid-MEM → FETCH next cycle, dmem_req=0.
- MC_CTRL_PERF_EN defined, run ADD, SW, J → retired_cnt=3; stall_cnt equals injected wait cycles.
